can_crc_engine: RTL and testbench

Parametrised serial CRC engine for the CAN 2.0 receive/transmit path. It is the successor to the fixed CRC-15 LFSR. It adds:
- configurable width, polynomial and seed;
- an explicit frame start;
- a check phase that validates the received CRC field;
- optional in-line bit destuffing.

It sits between the bit-timing/sampling logic and the frame FSM, consuming one sampled bit per `din_valid` strobe.

---
 rtl/can_crc_engine.sv | 188 ++++++++++++++++++
 tb/tb_can_crc_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_crc_engine.sv
// can_crc_engine: parametrised serial CRC engine for the CAN receive/transmit path.
// It consumes one sampled bit per din_valid strobe and runs four phases:
//   IDLE  : valid bits are ignored
//   CALC  : covered bits update the LFSR; on the data_last bit the CRC is frozen
//   CHECK : the received CRC field is shifted through the LFSR
//   DONE  : crc_ok/crc_err report the result (LFSR == 0 means match)
// A start pulse re-enters CALC from any state.
// Optional feature macro: CAN_CRC_DESTUFF_EN enables in-line bit destuffing.
// With the macro defined, a stuff bit that repeats the run value raises stuff_err.
// The current FSM state is exposed on dbg_state for observation.
//
// Handshake: din is consumed on each rising edge where din_valid is 1. There is
// no back-pressure. crc_valid is a one-cycle pulse. crc_ok, crc_err and
// stuff_err are levels.
module can_crc_engine #(
  parameter int unsigned          WIDTH = 15,
  parameter logic [WIDTH-1:0]     POLY  = 15'h4599,
  parameter logic [WIDTH-1:0]     INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  input  logic             data_last,
  output logic [WIDTH-1:0] crc,
  output logic             crc_valid,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             stuff_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic             crc_valid_q, crc_valid_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Working signals of the next-state process.
  logic             active;
  logic             accept;
  logic             in_calc;
  logic             fb;

`ifdef CAN_CRC_DESTUFF_EN
  logic [2:0]       run_cnt_q, run_cnt_d;
  logic             run_val_q, run_val_d;
  logic             stuff_err_q, stuff_err_d;
`endif

  // State and datapath registers; reset loads the seed and clears all flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= INIT;
      crc_q       <= '0;
      crc_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef CAN_CRC_DESTUFF_EN
      run_cnt_q   <= 3'd0;
      run_val_q   <= 1'b0;
      stuff_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      crc_q       <= crc_d;
      crc_valid_q <= crc_valid_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef CAN_CRC_DESTUFF_EN
      run_cnt_q   <= run_cnt_d;
      run_val_q   <= run_val_d;
      stuff_err_q <= stuff_err_d;
`endif
    end
  end

  // Next-state logic. The start pulse is applied first, so a bit arriving in
  // the same cycle is processed as the first frame bit against INIT.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    crc_d       = crc_q;
    crc_valid_d = 1'b0;
    ok_d        = ok_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    active      = 1'b0;
    accept      = 1'b0;
    in_calc     = 1'b0;
    fb          = 1'b0;
`ifdef CAN_CRC_DESTUFF_EN
    run_cnt_d   = run_cnt_q;
    run_val_d   = run_val_q;
    stuff_err_d = stuff_err_q;
`endif

    if (start) begin
      state_d = ST_CALC;
      lfsr_d  = INIT;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
`ifdef CAN_CRC_DESTUFF_EN
      run_cnt_d   = 3'd0;
      stuff_err_d = 1'b0;
`endif
    end

    active  = din_valid && ((state_d == ST_CALC) || (state_d == ST_CHECK));
    in_calc = (state_d == ST_CALC);
    accept  = active;

`ifdef CAN_CRC_DESTUFF_EN
    // Run tracking: after five equal bits the next bit is a stuff bit that
    // must differ from the run; it is dropped from the CRC and restarts the run.
    if (active) begin
      if (run_cnt_d == 3'd5) begin
        accept = 1'b0;
        if (din == run_val_d) begin
          stuff_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          run_cnt_d = 3'd1;
          run_val_d = din;
        end
      end else if ((run_cnt_d != 3'd0) && (din == run_val_d)) begin
        run_cnt_d = run_cnt_d + 3'd1;
      end else begin
        run_cnt_d = 3'd1;
        run_val_d = din;
      end
    end
`endif

    if (accept) begin
      fb     = din ^ lfsr_d[WIDTH-1];
      lfsr_d = {lfsr_d[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
      if (in_calc) begin
        if (data_last) begin
          crc_d       = lfsr_d;
          crc_valid_d = 1'b1;
          state_d     = ST_CHECK;
          cnt_d       = '0;
        end
      end else begin
        if (cnt_d == CNT_LAST) begin
          state_d = ST_DONE;
          ok_d    = (lfsr_d == '0);
          err_d   = (lfsr_d != '0);
        end
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  assign crc       = crc_q;
  assign crc_valid = crc_valid_q;
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;
  assign busy      = (state_q == ST_CALC) || (state_q == ST_CHECK);
  assign dbg_state = state_q;

`ifdef CAN_CRC_DESTUFF_EN
  assign stuff_err = stuff_err_q;
`else
  assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_can_crc_engine.sv
// Directed testbench for can_crc_engine (WIDTH=15, POLY=15'h4599, INIT=0).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_can_crc_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        din;
  logic        din_valid;
  logic        data_last;
  logic [14:0] crc;
  logic        crc_valid;
  logic        crc_ok;
  logic        crc_err;
  logic        stuff_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  can_crc_engine #(
    .WIDTH (15),
    .POLY  (15'h4599),
    .INIT  (15'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .data_last (data_last),
    .crc       (crc),
    .crc_valid (crc_valid),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .stuff_err (stuff_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one bit for one cycle, then idle for gap cycles. Entered and left on a falling edge.
  task automatic send_bit(input logic b, input logic last, input int gap);
    din       = b;
    din_valid = 1'b1;
    data_last = last;
    @(negedge clk);
    din_valid = 1'b0;
    data_last = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Shift n bits of a word MSB first; gaps optionally randomised.
  task automatic send_word(input logic [14:0] w, input int n, input logic last, input bit rnd);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(w[i], last, rnd ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  // One-cycle start pulse.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    data_last = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_crc",       32'(crc),       32'h0);
    check("rst_crc_valid", 32'(crc_valid), 32'h0);
    check("rst_ok",        32'(crc_ok),    32'h0);
    check("rst_err",       32'(crc_err),   32'h0);
    check("rst_stuff",     32'(stuff_err), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_state",     32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Bits in IDLE are ignored.
    send_bit(1'b1, 1'b1, 1);
    check("idle_ignore_valid", 32'(crc_valid), 32'h0);
    check("idle_ignore_crc",   32'(crc),       32'h0);

    // Single bit 1 with data_last -> 4599, one-cycle crc_valid.
    pulse_start();
    check("t1_busy_rise", 32'(busy), 32'h1);
    send_bit(1'b1, 1'b1, 0);
    check("t1_crc",       32'(crc),       32'h4599);
    check("t1_valid",     32'(crc_valid), 32'h1);
    check("t1_state",     32'(dbg_state), 32'(S_CHECK));
    @(negedge clk);
    check("t1_valid_pulse", 32'(crc_valid), 32'h0);

    // Bits 1,0 -> 4EAB; feed the field back -> crc_ok. data_last in CHECK is ignored.
    pulse_start();
    send_bit(1'b1, 1'b0, 0);
    check("t2_no_valid_mid", 32'(crc_valid), 32'h0);
    send_bit(1'b0, 1'b1, 0);
    check("t2_crc",   32'(crc),       32'h4EAB);
    check("t2_valid", 32'(crc_valid), 32'h1);
    send_word(15'h4EAB >> 1, 14, 1'b1, 1'b0);
    check("t2_busy_mid", 32'(busy),   32'h1);
    check("t2_ok_mid",   32'(crc_ok), 32'h0);
    send_bit(1'b1, 1'b0, 0);
    check("t2_ok",     32'(crc_ok),    32'h1);
    check("t2_err",    32'(crc_err),   32'h0);
    check("t2_busy",   32'(busy),      32'h0);
    check("t2_state",  32'(dbg_state), 32'(S_DONE));
    check("t2_frozen", 32'(crc),       32'h4EAB);
    send_bit(1'b0, 1'b0, 0);
    check("t2_done_hold", 32'(crc_ok), 32'h1);

    // Bit 3 of the CRC field inverted -> crc_err; next start clears both.
    pulse_start();
    check("t3_start_clr_ok", 32'(crc_ok), 32'h0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b1, 0);
    send_word(15'h4EA3, 15, 1'b0, 1'b0);
    check("t3_err",  32'(crc_err), 32'h1);
    check("t3_ok",   32'(crc_ok),  32'h0);
    check("t3_busy", 32'(busy),    32'h0);
    pulse_start();
    check("t3_clr_err", 32'(crc_err), 32'h0);
    check("t3_clr_ok",  32'(crc_ok),  32'h0);
    check("t3_crc_kept", 32'(crc),    32'h4EAB);

    // start together with a bit: processed against INIT, not the stale LFSR (4599).
    send_bit(1'b1, 1'b0, 0);
    start = 1'b1;
    send_bit(1'b1, 1'b1, 0);
    start = 1'b0;
    check("t4_start_bit_crc",   32'(crc),       32'h4599);
    check("t4_start_bit_valid", 32'(crc_valid), 32'h1);

`ifdef CAN_CRC_DESTUFF_EN
    // Five zeros, stuff 1, then 1 with data_last -> 4599.
    pulse_start();
    send_word(15'h0000, 5, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 0);
    check("t5_stuff_no_valid", 32'(crc_valid), 32'h0);
    send_bit(1'b1, 1'b1, 0);
    check("t5_destuff_crc", 32'(crc),       32'h4599);
    check("t5_stuff_err0",  32'(stuff_err), 32'h0);
    // Six zeros -> stuff error, IDLE.
    pulse_start();
    send_word(15'h0000, 6, 1'b0, 1'b0);
    check("t5_stuff_err",   32'(stuff_err), 32'h1);
    check("t5_stuff_state", 32'(dbg_state), 32'(S_IDLE));
    check("t5_stuff_busy",  32'(busy),      32'h0);
    send_bit(1'b1, 1'b1, 0);
    check("t5_after_err_valid", 32'(crc_valid), 32'h0);
    check("t5_after_err_ok",    32'(crc_ok),    32'h0);
    check("t5_after_err_err",   32'(crc_err),   32'h0);
`else
    // No destuffing: six zeros are all covered bits, then 1 with data_last -> 4599.
    pulse_start();
    send_word(15'h0000, 6, 1'b0, 1'b0);
    check("t5_nostuff_err", 32'(stuff_err), 32'h0);
    check("t5_nostuff_busy", 32'(busy),     32'h1);
    send_bit(1'b1, 1'b1, 0);
    check("t5_nostuff_crc", 32'(crc),       32'h4599);
    send_word(15'h0000, 6, 1'b0, 1'b0);
    check("t5_nostuff_err2", 32'(stuff_err), 32'h0);
`endif

    // start reissued mid-CALC: frame restarts, crc keeps its old value.
    pulse_start();
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    pulse_start();
    check("t6_restart_busy",  32'(busy),      32'h1);
    check("t6_restart_crc",   32'(crc),       32'h4599);
    check("t6_restart_valid", 32'(crc_valid), 32'h0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b1, 0);
    check("t6_crc", 32'(crc), 32'h4EAB);

    // Reset mid-CHECK: everything back to reset values.
    send_word(15'h4EAB >> 10, 5, 1'b0, 1'b0);
    check("t7_in_check", 32'(dbg_state), 32'(S_CHECK));
    rst_n = 1'b0;
    #1;
    check("t7_rst_crc",   32'(crc),       32'h0);
    check("t7_rst_busy",  32'(busy),      32'h0);
    check("t7_rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("t7_rst_ok",    32'(crc_ok),    32'h0);
    check("t7_rst_err",   32'(crc_err),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean frame with randomised din_valid gaps.
    pulse_start();
    send_bit(1'b1, 1'b0, int'($urandom_range(0, 3)));
    din       = 1'b0;
    din_valid = 1'b1;
    data_last = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    data_last = 1'b0;
    check("t8_valid", 32'(crc_valid), 32'h1);
    check("t8_crc",   32'(crc),       32'h4EAB);
    repeat (int'($urandom_range(0, 3))) @(negedge clk);
    send_word(15'h4EAB, 15, 1'b0, 1'b1);
    check("t8_ok",   32'(crc_ok),  32'h1);
    check("t8_err",  32'(crc_err), 32'h0);
    check("t8_busy", 32'(busy),    32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
